// File: rtl/conv_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : conv_frame_ctrl
// Brief   : Frame sequencer for the 2x2 convolution datapath: raster position
//           tracking, line-buffer write control, window-valid and out_valid.
// Revision: 1.0 - initial release
// ============================================================================
module conv_frame_ctrl #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int PIPE_LAT = 1,
  parameter int CW       = $clog2(IMG_W),
  parameter int RW       = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_wr_en,
  output logic [CW-1:0] lb_addr,
  output logic          win_valid,
  output logic          out_valid,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          busy,
  output logic          done
);

  localparam int WCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0]  c_col_last  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  c_row_last  = RW'(IMG_H - 1);
  localparam logic [WCW-1:0] c_wait_last = WCW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [WCW-1:0]    r_wait;
  logic [PIPE_LAT-1:0] r_pipe;
  logic              w_accept;
  logic              w_last_px;
  logic              w_win;

  assign in_ready  = (r_state == S_RUN);
  assign w_accept  = in_valid & in_ready;
  assign w_last_px = (r_row == c_row_last) && (r_col == c_col_last);
  // Column 0 never closes a window, so nothing straddles the row wrap.
  assign w_win     = w_accept & (r_row != '0) & (r_col != '0);

  assign lb_wr_en  = w_accept;
  assign lb_addr   = r_col;
  assign win_valid = w_win;
  assign row       = r_row;
  assign col       = r_col;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_valid = r_pipe[PIPE_LAT-1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last_px) w_state_nxt = S_FLUSH;
      S_FLUSH: if (r_wait == c_wait_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_wait <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_accept) begin
        if (r_col == c_col_last) begin
          r_col <= '0;
          r_row <= w_last_px ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // Counts FLUSH cycles; held at zero elsewhere so each flush starts clean.
      if (r_state == S_FLUSH) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  generate
    if (PIPE_LAT == 1) begin : g_pipe_one
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= w_win;
        end
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= {r_pipe[PIPE_LAT-2:0], w_win};
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_frame_ctrl
// Brief   : Scoreboard bench for conv_frame_ctrl, 4x4 frame, latency 1 and 3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_conv_frame_ctrl;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic in_valid = 1'b0;

  logic       in_ready_a, lb_wr_en_a, win_valid_a, out_valid_a, busy_a, done_a;
  logic [1:0] lb_addr_a, row_a, col_a;
  logic       in_ready_b, lb_wr_en_b, win_valid_b, out_valid_b, busy_b, done_b;
  logic [1:0] lb_addr_b, row_b, col_b;

  conv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid),
    .in_ready(in_ready_a), .lb_wr_en(lb_wr_en_a), .lb_addr(lb_addr_a),
    .win_valid(win_valid_a), .out_valid(out_valid_a), .row(row_a), .col(col_a),
    .busy(busy_a), .done(done_a)
  );

  conv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid),
    .in_ready(in_ready_b), .lb_wr_en(lb_wr_en_b), .lb_addr(lb_addr_b),
    .win_valid(win_valid_b), .out_valid(out_valid_b), .row(row_b), .col(col_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int cyc;
    int addr;
    int row;
    int win;
  } wr_t;

  wr_t q_wr_a[$];
  wr_t q_wr_b[$];
  int  q_out_a[$];
  int  q_out_b[$];
  int  q_done_a[$];
  int  q_done_b[$];
  wr_t e_a;
  wr_t e_b;
  int  last;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever a DUT presents an event.
  always @(negedge clk) begin
    if (lb_wr_en_a) begin
      check("wr_queue_a", q_wr_a.size() > 0, 1);
      if (q_wr_a.size() > 0) begin
        e_a = q_wr_a.pop_front();
        check("wr_cyc_a", cyc, e_a.cyc);
        check("lb_addr_a", lb_addr_a, e_a.addr);
        check("col_a", col_a, e_a.addr);
        check("row_a", row_a, e_a.row);
        check("win_a", win_valid_a, e_a.win);
      end
    end else begin
      check("win_idle_a", win_valid_a, 0);
    end
    if (lb_wr_en_b) begin
      check("wr_queue_b", q_wr_b.size() > 0, 1);
      if (q_wr_b.size() > 0) begin
        e_b = q_wr_b.pop_front();
        check("wr_cyc_b", cyc, e_b.cyc);
        check("lb_addr_b", lb_addr_b, e_b.addr);
        check("col_b", col_b, e_b.addr);
        check("row_b", row_b, e_b.row);
        check("win_b", win_valid_b, e_b.win);
      end
    end else begin
      check("win_idle_b", win_valid_b, 0);
    end
    if (out_valid_a) begin
      check("out_queue_a", q_out_a.size() > 0, 1);
      if (q_out_a.size() > 0) check("out_cyc_a", cyc, q_out_a.pop_front());
    end
    if (out_valid_b) begin
      check("out_queue_b", q_out_b.size() > 0, 1);
      if (q_out_b.size() > 0) check("out_cyc_b", cyc, q_out_b.pop_front());
    end
    if (done_a) begin
      check("done_queue_a", q_done_a.size() > 0, 1);
      if (q_done_a.size() > 0) check("done_cyc_a", cyc, q_done_a.pop_front());
    end
    if (done_b) begin
      check("done_queue_b", q_done_b.size() > 0, 1);
      if (q_done_b.size() > 0) check("done_cyc_b", cyc, q_done_b.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic push_px(input int r, input int c);
    wr_t e;
    int  w;
    w = (r >= 1 && c >= 1) ? 1 : 0;
    e.cyc = cyc; e.addr = c; e.row = r; e.win = w;
    q_wr_a.push_back(e);
    q_wr_b.push_back(e);
    if (w == 1) begin
      q_out_a.push_back(cyc + 1);
      q_out_b.push_back(cyc + 3);
    end
  endtask

  task automatic start_frame();
    tick();
    in_valid = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
  endtask

  // Feeds one frame; abort_n > 0 stops after that many accepts.
  task automatic stream(input bit toggle, input bit poke, input int abort_n, output int last_cyc);
    int r, c, n, k;
    r = 0; c = 0; n = 0; k = 0;
    last_cyc = -1;
    while (k < 200) begin
      tick();
      in_valid = toggle ? (k % 2 == 0) : 1'b1;
      if (poke && (k == 3 || k == 9)) begin
        start_a = 1'b1;
        start_b = 1'b1;
      end
      k++;
      if (in_valid) begin
        push_px(r, c);
        n++;
        if (c == W - 1) begin c = 0; r++; end else c++;
        if (n == W * H || n == abort_n) begin
          last_cyc = cyc;
          break;
        end
      end
    end
    if (n == W * H) begin
      q_done_a.push_back(last_cyc + 2);
      q_done_b.push_back(last_cyc + 4);
    end
  endtask

  // Cycles after the last accept; gap=1 pokes start in FLUSH/DONE and restarts
  // each instance on the first cycle it is back in IDLE.
  task automatic post_frame(input int last_cyc, input bit gap);
    for (int d = 1; d <= 6; d++) begin
      tick();
      in_valid = 1'b0;
      if (gap) begin
        start_a = (d <= 3);
        start_b = (d <= 5);
      end
      @(negedge clk);
      check("flush_cyc", cyc, last_cyc + d);
      if (d <= 3) check("in_ready_flush_b", in_ready_b, 0);
      if (d == 1) check("in_ready_flush_a", in_ready_a, 0);
      if (d <= 2) check("busy_a", busy_a, 1);
      if (d == 3) check("idle_a", busy_a, 0);
      if (d <= 4) check("busy_b", busy_b, 1);
      if (d == 5) check("idle_b", busy_b, 0);
      if (gap && d == 4) begin
        check("restart_busy_a", busy_a, 1);
        check("restart_ready_a", in_ready_a, 1);
        check("restart_pos_a", {row_a, col_a}, 0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_outs_a", {in_ready_a, lb_wr_en_a, win_valid_a, out_valid_a, busy_a, done_a,
                         lb_addr_a, row_a, col_a}, 0);
    check("rst_outs_b", {in_ready_b, lb_wr_en_b, win_valid_b, out_valid_b, busy_b, done_b,
                         lb_addr_b, row_b, col_b}, 0);
    tick();
    rst = 1'b1;

    // in_valid while IDLE is not consumed
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 1'b1;
      @(negedge clk);
      check("idle_in_a", {in_ready_a, lb_wr_en_a, busy_a, row_a, col_a}, 0);
      check("idle_in_b", {in_ready_b, lb_wr_en_b, busy_b, row_b, col_b}, 0);
    end

    start_frame(); stream(1'b0, 1'b0, 0, last); post_frame(last, 1'b0);
    start_frame(); stream(1'b1, 1'b0, 0, last); post_frame(last, 1'b0);
    start_frame(); stream(1'b0, 1'b1, 0, last); post_frame(last, 1'b1);
    stream(1'b0, 1'b0, 0, last); post_frame(last, 1'b0);

    // Reset mid-frame right after the 7th accept
    start_frame(); stream(1'b0, 1'b0, 7, last);
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    q_out_a.delete();
    q_out_b.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_outs_a", {in_ready_a, lb_wr_en_a, win_valid_a, out_valid_a, busy_a, done_a,
                             lb_addr_a, row_a, col_a}, 0);
      check("abort_outs_b", {in_ready_b, lb_wr_en_b, win_valid_b, out_valid_b, busy_b, done_b,
                             lb_addr_b, row_b, col_b}, 0);
      if (i < 2) tick();
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("post_rst_a", {out_valid_a, busy_a}, 0);
      check("post_rst_b", {out_valid_b, busy_b}, 0);
    end

    start_frame(); stream(1'b0, 1'b0, 0, last); post_frame(last, 1'b0);

    check("left_wr_a", q_wr_a.size(), 0);
    check("left_wr_b", q_wr_b.size(), 0);
    check("left_out_a", q_out_a.size(), 0);
    check("left_out_b", q_out_b.size(), 0);
    check("left_done_a", q_done_a.size(), 0);
    check("left_done_b", q_done_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
